// File: rtl/i2c_master_reader.sv
// I2C initiator: writes a command byte, repeated-START, then reads 1..2 bytes MSB-first.
// Optional feature macro: I2C_CLK_STRETCH_EN (honour target SCL stretching in the high phase).
module i2c_master_reader #(
   parameter int CLK_DIV = 125,
   parameter int ADDR_W  = 7
) (
   input  logic              CLCK,
   input  logic              RST,
   input  logic              START,
   input  logic [ADDR_W-1:0] DEV_ADDR,
   input  logic [7:0]        CMD,
   input  logic              NBYTES,
   input  logic              SCL_IN,
   input  logic              SDA_IN,
   output logic              SCL_OE,
   output logic              SDA_OE,
   output logic              BUSY,
   output logic              DONE,
   output logic              NACK,
   output logic [15:0]       RDATA
);
   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_STA  = 4'd1,
      ST_TXA  = 4'd2,
      ST_AK1  = 4'd3,
      ST_TXC  = 4'd4,
      ST_AK2  = 4'd5,
      ST_RSTA = 4'd6,
      ST_AK3  = 4'd7,
      ST_RXB  = 4'd8,
      ST_MAK  = 4'd9,
      ST_STO  = 4'd10
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [1:0]        phase_q, phase_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        tx_q, tx_d;
   logic [15:0]       rx_q, rx_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        cmd_q, cmd_d;
   logic              nbytes_q, nbytes_d;
   logic              rd_q, rd_d;         // address frame with R/W=1 is in progress
   logic              second_q, second_d;
   logic              ack_q, ack_d;       // SDA level captured in the ACK slot, 1 = NACK
   logic              nackf_q, nackf_d;
   logic              scl_oe_q, scl_oe_d;
   logic              sda_oe_q, sda_oe_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              nack_q, nack_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              stall_s;
   logic              tick_s;
   logic              scl_low_s;

`ifdef I2C_CLK_STRETCH_EN
   assign stall_s = (phase_q == 2'd2) && !scl_oe_q && !SCL_IN;
`else
   logic unused_scl_in_s;
   assign unused_scl_in_s = SCL_IN;
   assign stall_s         = 1'b0;
`endif

   assign tick_s    = (state_q != ST_IDLE) && !stall_s && (div_q == DIV_LAST);
   assign scl_low_s = (phase_q == 2'd0) || (phase_q == 2'd3);

   // Quarter-bit divider; restarts from zero while a stretched SCL is held low.
   always_comb begin
      if ((state_q == ST_IDLE) || stall_s || (div_q == DIV_LAST)) begin
         div_d = {DIV_W{1'b0}};
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Open-drain line drive decoded from state and quarter phase.
   always_comb begin
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
         ST_STA: begin
            scl_oe_d = phase_q[1];
            sda_oe_d = (phase_q != 2'd0);
         end
         ST_RSTA: begin
            scl_oe_d = scl_low_s;
            sda_oe_d = phase_q[1];
         end
         ST_STO: begin
            scl_oe_d = (phase_q == 2'd0);
            sda_oe_d = !phase_q[1];
         end
         ST_TXA, ST_TXC: begin
            scl_oe_d = scl_low_s;
            sda_oe_d = !tx_q[7];
         end
         ST_MAK: begin
            scl_oe_d = scl_low_s;
            sda_oe_d = nbytes_q && !second_q;
         end
         ST_AK1, ST_AK2, ST_AK3, ST_RXB: begin
            scl_oe_d = scl_low_s;
            sda_oe_d = 1'b0;
         end
         default: begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
         end
      endcase
   end

   // Transaction sequencing: capture on START, sample in q2, advance state at end of q3.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      addr_d   = addr_q;
      cmd_d    = cmd_q;
      nbytes_d = nbytes_q;
      rd_d     = rd_q;
      second_d = second_q;
      ack_d    = ack_q;
      nackf_d  = nackf_q;
      done_d   = 1'b0;
      nack_d   = nack_q;
      rdata_d  = rdata_q;
      if (state_q == ST_IDLE) begin
         if (START && !busy_q) begin
            state_d  = ST_STA;
            phase_d  = 2'd0;
            bit_d    = 3'd0;
            addr_d   = DEV_ADDR;
            cmd_d    = CMD;
            nbytes_d = NBYTES;
            rx_d     = 16'h0000;
            rd_d     = 1'b0;
            second_d = 1'b0;
            ack_d    = 1'b0;
            nackf_d  = 1'b0;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (tick_s && (phase_q != 2'd3)) begin
         phase_d = phase_q + 2'd1;
         if (phase_q == 2'd2) begin
            case (state_q)
               ST_AK1, ST_AK2, ST_AK3: ack_d = SDA_IN;
               ST_RXB:                 rx_d  = {rx_q[14:0], SDA_IN};
               default:                ack_d = ack_q;
            endcase
         end else begin
            ack_d = ack_q;
         end
      end else if (tick_s) begin
         phase_d = 2'd0;
         case (state_q)
            ST_STA: begin
               state_d = ST_TXA;
               tx_d    = {addr_q, 1'b0};
               bit_d   = 3'd0;
            end
            ST_TXA, ST_TXC: begin
               tx_d  = {tx_q[6:0], 1'b0};
               bit_d = bit_q + 3'd1;
               if (bit_q != 3'd7) begin
                  state_d = state_q;
               end else if (state_q == ST_TXC) begin
                  state_d = ST_AK2;
               end else if (rd_q) begin
                  state_d = ST_AK3;
               end else begin
                  state_d = ST_AK1;
               end
            end
            ST_AK1: begin
               if (ack_q) begin
                  state_d = ST_STO;
                  nackf_d = 1'b1;
               end else begin
                  state_d = ST_TXC;
                  tx_d    = cmd_q;
                  bit_d   = 3'd0;
               end
            end
            ST_AK2: begin
               if (ack_q) begin
                  state_d = ST_STO;
                  nackf_d = 1'b1;
               end else begin
                  state_d = ST_RSTA;
               end
            end
            ST_RSTA: begin
               state_d = ST_TXA;
               tx_d    = {addr_q, 1'b1};
               rd_d    = 1'b1;
               bit_d   = 3'd0;
            end
            ST_AK3: begin
               if (ack_q) begin
                  state_d = ST_STO;
                  nackf_d = 1'b1;
               end else begin
                  state_d = ST_RXB;
                  bit_d   = 3'd0;
               end
            end
            ST_RXB: begin
               bit_d   = bit_q + 3'd1;
               state_d = (bit_q == 3'd7) ? ST_MAK : ST_RXB;
            end
            ST_MAK: begin
               if (nbytes_q && !second_q) begin
                  state_d  = ST_RXB;
                  second_d = 1'b1;
               end else begin
                  state_d = ST_STO;
               end
            end
            ST_STO: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               nack_d  = nackf_q;
               rdata_d = nackf_q ? rdata_q : rx_q;
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
      busy_d = (state_d != ST_IDLE) || done_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLCK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         div_q    <= {DIV_W{1'b0}};
         phase_q  <= 2'd0;
         bit_q    <= 3'd0;
         tx_q     <= 8'h00;
         rx_q     <= 16'h0000;
         addr_q   <= {ADDR_W{1'b0}};
         cmd_q    <= 8'h00;
         nbytes_q <= 1'b0;
         rd_q     <= 1'b0;
         second_q <= 1'b0;
         ack_q    <= 1'b0;
         nackf_q  <= 1'b0;
         scl_oe_q <= 1'b0;
         sda_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         nack_q   <= 1'b0;
         rdata_q  <= 16'h0000;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         phase_q  <= phase_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         addr_q   <= addr_d;
         cmd_q    <= cmd_d;
         nbytes_q <= nbytes_d;
         rd_q     <= rd_d;
         second_q <= second_d;
         ack_q    <= ack_d;
         nackf_q  <= nackf_d;
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         nack_q   <= nack_d;
         rdata_q  <= rdata_d;
      end
   end

   assign SCL_OE = scl_oe_q;
   assign SDA_OE = sda_oe_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign NACK   = nack_q;
   assign RDATA  = rdata_q;

endmodule
